// File: rtl/rx_crc32_check.sv
// Receive-side Ethernet FCS checker: 1-cycle AXIS pass-through plus CRC-32 residue verdict.
// Optional macro RUNT_CHECK_EN adds a minimum-length (runt) check to the verdict.
module rx_crc32_check #(
    parameter logic [31:0] P_CRC_INIT  = 32'hFFFFFFFF,
    parameter logic [31:0] P_RESIDUE   = 32'hDEBB20E3,
    parameter logic [15:0] P_MIN_BYTES = 16'd64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] s_axis_rdata,
    input  logic [79:0] s_axis_ruser,
    input  logic [7:0]  s_axis_rkeep,
    input  logic        s_axis_rlast,
    input  logic        s_axis_rvalid,
    output logic [63:0] m_axis_rdata,
    output logic [79:0] m_axis_ruser,
    output logic [7:0]  m_axis_rkeep,
    output logic        m_axis_rlast,
    output logic        m_axis_rvalid,
    output logic        o_crc_valid,
    output logic        o_crc_error
);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic        in_frame;
    logic [31:0] crc_q;
    logic        bad_q;
    logic        fin_pend;
    logic [31:0] fin_crc;
    logic        fin_bad;
    logic        fin_runt;

    logic        start;
    logic        beat_last;
    logic [31:0] crc_base;
    logic [31:0] fold [0:8];
    logic [3:0]  nbytes;
    logic [31:0] crc_next;
    logic        keep_ok_last;
    logic        keep_bad;
    logic        bad_next;

    assign start     = s_axis_rvalid & ~in_frame;
    assign beat_last = s_axis_rvalid & s_axis_rlast;
    assign crc_base  = start ? P_CRC_INIT : crc_q;

    // Chain of byte folds; the tap at the keep popcount is the beat's result.
    always_comb begin
        fold[0] = crc_base;
        for (int k = 1; k <= 8; k++)
            fold[k] = crc_byte(fold[k-1], s_axis_rdata[8*(k-1) +: 8]);
        nbytes = '0;
        for (int i = 0; i < 8; i++)
            nbytes = nbytes + {3'd0, s_axis_rkeep[i]};
        crc_next = fold[8];
        for (int k = 0; k < 8; k++)
            if (nbytes == k[3:0])
                crc_next = fold[k];
    end

    assign keep_ok_last = (s_axis_rkeep != 8'h00) &&
                          ((s_axis_rkeep & (s_axis_rkeep + 8'd1)) == 8'h00);
    assign keep_bad     = s_axis_rlast ? ~keep_ok_last : (s_axis_rkeep != 8'hFF);
    assign bad_next     = (~start & bad_q) | keep_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_axis_rdata  <= '0;
            m_axis_ruser  <= '0;
            m_axis_rkeep  <= '0;
            m_axis_rlast  <= 1'b0;
            m_axis_rvalid <= 1'b0;
        end else begin
            m_axis_rdata  <= s_axis_rdata;
            m_axis_ruser  <= s_axis_ruser;
            m_axis_rkeep  <= s_axis_rkeep;
            m_axis_rlast  <= s_axis_rlast;
            m_axis_rvalid <= s_axis_rvalid;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_frame <= 1'b0;
            crc_q    <= P_CRC_INIT;
            bad_q    <= 1'b0;
        end else if (s_axis_rvalid) begin
            in_frame <= ~s_axis_rlast;
            crc_q    <= crc_next;
            bad_q    <= bad_next;
        end
    end

    // Verdict is snapshotted at rlast so a following frame can reuse crc_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fin_pend    <= 1'b0;
            fin_crc     <= '0;
            fin_bad     <= 1'b0;
            o_crc_valid <= 1'b0;
            o_crc_error <= 1'b0;
        end else begin
            fin_pend <= beat_last;
            if (beat_last) begin
                fin_crc <= crc_next;
                fin_bad <= bad_next;
            end
            o_crc_valid <= fin_pend;
            o_crc_error <= fin_pend &
                           ((fin_crc != P_RESIDUE) | fin_bad | fin_runt);
        end
    end

`ifdef RUNT_CHECK_EN
    logic [15:0] cnt_q;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_next;

    assign cnt_sum  = {1'b0, start ? 16'd0 : cnt_q} + {13'd0, nbytes};
    assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            fin_runt <= 1'b0;
        end else begin
            if (s_axis_rvalid)
                cnt_q <= cnt_next;
            if (beat_last)
                fin_runt <= (cnt_next < P_MIN_BYTES);
        end
    end
`else
    logic unused_min;
    assign unused_min = ^P_MIN_BYTES;
    assign fin_runt   = 1'b0;
`endif

endmodule

// File: tb/tb_rx_crc32_check.sv
// Directed self-checking bench for rx_crc32_check.
// Define RUNT_CHECK_EN for both bench and RTL to exercise the runt check.
module tb_rx_crc32_check;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [63:0] s_axis_rdata;
    logic [79:0] s_axis_ruser;
    logic [7:0]  s_axis_rkeep;
    logic        s_axis_rlast;
    logic        s_axis_rvalid;
    logic [63:0] m_axis_rdata;
    logic [79:0] m_axis_ruser;
    logic [7:0]  m_axis_rkeep;
    logic        m_axis_rlast;
    logic        m_axis_rvalid;
    logic        o_crc_valid;
    logic        o_crc_error;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] G0 = 64'h3837363534333231;
    localparam logic [63:0] G1 = 64'h000000CBF4392639;
    localparam logic [63:0] C0 = 64'h3837363534343231;

    rx_crc32_check dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .s_axis_rdata (s_axis_rdata),
        .s_axis_ruser (s_axis_ruser),
        .s_axis_rkeep (s_axis_rkeep),
        .s_axis_rlast (s_axis_rlast),
        .s_axis_rvalid(s_axis_rvalid),
        .m_axis_rdata (m_axis_rdata),
        .m_axis_ruser (m_axis_ruser),
        .m_axis_rkeep (m_axis_rkeep),
        .m_axis_rlast (m_axis_rlast),
        .m_axis_rvalid(m_axis_rvalid),
        .o_crc_valid  (o_crc_valid),
        .o_crc_error  (o_crc_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic beat(input logic v, input logic [63:0] d,
                        input logic [7:0] k, input logic l);
        s_axis_rvalid = v;
        s_axis_rdata  = d;
        s_axis_rkeep  = k;
        s_axis_rlast  = l;
        s_axis_ruser  = {16'h5A00, d};
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        beat(1'b0, 64'h0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        beat(1'b1, G0, 8'hFF, 1'b1);
        beat(1'b1, G1, 8'h1F, 1'b1);
        checks++;
        if (m_axis_rvalid !== 1'b0 || m_axis_rdata !== 64'h0 || m_axis_rlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_axis: got v=%b d=%h l=%b want 0", m_axis_rvalid, m_axis_rdata, m_axis_rlast);
        end
        checks++;
        if (o_crc_valid !== 1'b0 || o_crc_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_verdict: got v=%b e=%b want 0 0", o_crc_valid, o_crc_error);
        end
        i_rst_n = 1'b1;
        idle();
        idle();
    endtask

    task automatic test_good_frame();
        beat(1'b1, G0, 8'hFF, 1'b0);
        checks++;
        if (m_axis_rdata !== G0 || m_axis_rvalid !== 1'b1 || m_axis_rlast !== 1'b0 ||
            m_axis_ruser !== {16'h5A00, G0} || m_axis_rkeep !== 8'hFF) begin
            errors++;
            $display("FAIL good_beat0: got d=%h u=%h k=%h v=%b l=%b want d=%h", m_axis_rdata,
                     m_axis_ruser, m_axis_rkeep, m_axis_rvalid, m_axis_rlast, G0);
        end
        beat(1'b1, G1, 8'h1F, 1'b1);
        checks++;
        if (m_axis_rdata !== G1 || m_axis_rkeep !== 8'h1F || m_axis_rlast !== 1'b1 ||
            o_crc_valid !== 1'b0) begin
            errors++;
            $display("FAIL good_beat1: got d=%h k=%h l=%b cv=%b want d=%h k=1f l=1 cv=0",
                     m_axis_rdata, m_axis_rkeep, m_axis_rlast, o_crc_valid, G1);
        end
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b0) begin
            errors++;
            $display("FAIL good_verdict: got v=%b e=%b want 1 0", o_crc_valid, o_crc_error);
        end
        idle();
        checks++;
        if (o_crc_valid !== 1'b0 || o_crc_error !== 1'b0) begin
            errors++;
            $display("FAIL good_pulse_width: got v=%b e=%b want 0 0", o_crc_valid, o_crc_error);
        end
    endtask

    task automatic test_passthrough_idle();
        beat(1'b0, 64'hDEADBEEFCAFEF00D, 8'hA5, 1'b1);
        checks++;
        if (m_axis_rdata !== 64'hDEADBEEFCAFEF00D || m_axis_rkeep !== 8'hA5 ||
            m_axis_rlast !== 1'b1 || m_axis_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_passthrough: got d=%h k=%h l=%b v=%b want deadbeefcafef00d a5 1 0",
                     m_axis_rdata, m_axis_rkeep, m_axis_rlast, m_axis_rvalid);
        end
        idle();
        checks++;
        if (o_crc_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_verdict: got v=%b want 0", o_crc_valid);
        end
    endtask

    task automatic test_corrupt();
        beat(1'b1, C0, 8'hFF, 1'b0);
        beat(1'b1, G1, 8'h1F, 1'b1);
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b1) begin
            errors++;
            $display("FAIL corrupt_verdict: got v=%b e=%b want 1 1", o_crc_valid, o_crc_error);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        beat(1'b1, G0, 8'hFF, 1'b0);
        idle();
        idle();
        idle();
        checks++;
        if (o_crc_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_no_verdict: got v=%b want 0", o_crc_valid);
        end
        beat(1'b1, G1, 8'h1F, 1'b1);
        beat(1'b1, C0, 8'hFF, 1'b0);
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b0 || m_axis_rdata !== C0) begin
            errors++;
            $display("FAIL b2b_first: got v=%b e=%b d=%h want 1 0 %h", o_crc_valid, o_crc_error,
                     m_axis_rdata, C0);
        end
        beat(1'b1, G1, 8'h1F, 1'b1);
        checks++;
        if (o_crc_valid !== 1'b0 || m_axis_rdata !== G1 || m_axis_rlast !== 1'b1) begin
            errors++;
            $display("FAIL b2b_mid: got v=%b d=%h l=%b want 0 %h 1", o_crc_valid, m_axis_rdata,
                     m_axis_rlast, G1);
        end
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got v=%b e=%b want 1 1", o_crc_valid, o_crc_error);
        end
        idle();
    endtask

    task automatic test_bad_keep();
        beat(1'b1, G0, 8'hFF, 1'b0);
        beat(1'b1, G1, 8'h15, 1'b1);
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b1) begin
            errors++;
            $display("FAIL keep_last_15: got v=%b e=%b want 1 1", o_crc_valid, o_crc_error);
        end
        beat(1'b1, G0, 8'h7F, 1'b0);
        beat(1'b1, G1, 8'h1F, 1'b1);
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b1) begin
            errors++;
            $display("FAIL keep_mid_7f: got v=%b e=%b want 1 1", o_crc_valid, o_crc_error);
        end
        beat(1'b1, G0, 8'h00, 1'b1);
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b1) begin
            errors++;
            $display("FAIL keep_single_00: got v=%b e=%b want 1 1", o_crc_valid, o_crc_error);
        end
        beat(1'b1, G0, 8'hFF, 1'b0);
        beat(1'b1, G1, 8'h1F, 1'b1);
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b0) begin
            errors++;
            $display("FAIL keep_flag_clears: got v=%b e=%b want 1 0", o_crc_valid, o_crc_error);
        end
        idle();
    endtask

    task automatic test_reset_mid_frame();
        int pulses;
        int errs;
        beat(1'b1, G0, 8'hFF, 1'b0);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_rvalid !== 1'b0 || m_axis_rdata !== 64'h0 || o_crc_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got v=%b d=%h cv=%b want 0 0 0", m_axis_rvalid,
                     m_axis_rdata, o_crc_valid);
        end
        idle();
        idle();
        i_rst_n = 1'b1;
        pulses = 0;
        errs   = 0;
        beat(1'b1, G0, 8'hFF, 1'b0);
        beat(1'b1, G1, 8'h1F, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle();
            if (o_crc_valid === 1'b1) pulses++;
            if (o_crc_error === 1'b1) errs++;
        end
        checks++;
        if (pulses !== 1 || errs !== 0) begin
            errors++;
            $display("FAIL midrst_verdict: got pulses=%0d errs=%0d want 1 0", pulses, errs);
        end
    endtask

`ifdef RUNT_CHECK_EN
    function automatic logic [31:0] tb_crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic test_runt();
        logic [7:0]  b [0:63];
        logic [31:0] c;
        logic [63:0] d;
        beat(1'b1, G0, 8'hFF, 1'b0);
        beat(1'b1, G1, 8'h1F, 1'b1);
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b1) begin
            errors++;
            $display("FAIL runt_13: got v=%b e=%b want 1 1", o_crc_valid, o_crc_error);
        end
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            b[i] = 8'(i + 1);
            c = tb_crc_byte(c, b[i]);
        end
        c = ~c;
        b[60] = c[7:0];
        b[61] = c[15:8];
        b[62] = c[23:16];
        b[63] = c[31:24];
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 8; k++)
                d[8*k +: 8] = b[8*j + k];
            beat(1'b1, d, 8'hFF, (j == 7));
        end
        idle();
        checks++;
        if (o_crc_valid !== 1'b1 || o_crc_error !== 1'b0) begin
            errors++;
            $display("FAIL runt_64: got v=%b e=%b want 1 0", o_crc_valid, o_crc_error);
        end
        idle();
    endtask
`endif

    initial begin
        i_rst_n       = 1'b0;
        s_axis_rvalid = 1'b0;
        s_axis_rdata  = '0;
        s_axis_ruser  = '0;
        s_axis_rkeep  = '0;
        s_axis_rlast  = 1'b0;
        test_reset();
`ifdef RUNT_CHECK_EN
        test_runt();
`else
        test_good_frame();
        test_passthrough_idle();
        test_corrupt();
        test_back_to_back();
        test_bad_keep();
        test_reset_mid_frame();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_crc32_check.md
Name: rx_crc32_check

Overview:
Receive-side Ethernet FCS checker sitting directly upstream of the CRC drop/buffer stage in the 10G MAC RX path.
- Takes the 64-bit AXIS frame stream, FCS included, from the RX decoder.
- Forwards the stream unchanged with 1-cycle latency.
- Computes CRC-32 over every valid byte using the residue method.
- Emits a one-cycle crc_valid/crc_error verdict per frame, timed for the downstream rollback logic.

Parameters:
P_CRC_INIT, 32'hFFFFFFFF, CRC register value loaded at frame start.
P_RESIDUE, 32'hDEBB20E3, uninverted CRC register value expected after the FCS of a good frame.
P_MIN_BYTES, 16'd64, minimum legal frame length in bytes, FCS included; used only with RUNT_CHECK_EN.

Ports:
i_clk  input  1  single clock for the whole block.
i_rst_n  input  1  asynchronous, active-low reset.
s_axis_rdata  input  64  frame data; byte0 (first on wire) in [7:0].
s_axis_ruser  input  80  sideband (length/user); passed through untouched.
s_axis_rkeep  input  8  byte enables, contiguous from LSB.
s_axis_rlast  input  1  last beat of frame.
s_axis_rvalid  input  1  beat valid; no tready, no backpressure.
m_axis_rdata  output  64  registered copy of s_axis_rdata.
m_axis_ruser  output  80  registered copy of s_axis_ruser.
m_axis_rkeep  output  8  registered copy of s_axis_rkeep.
m_axis_rlast  output  1  registered copy of s_axis_rlast.
m_axis_rvalid  output  1  registered copy of s_axis_rvalid.
o_crc_valid  output  1  one-cycle pulse: verdict for the frame just ended.
o_crc_error  output  1  qualified by o_crc_valid: 1 = bad frame.

Behaviour:
- Reset (i_rst_n low, async): every output is 0; CRC register = P_CRC_INIT; in_frame = 0; byte counter = 0.
- Pass-through: every m_axis_* output equals the matching s_axis_* input delayed exactly 1 clock, unconditionally, including data when rvalid is 0.
- Frame tracking:
  - A beat with rvalid=1 and in_frame=0 is the start-of-frame beat. The CRC for that beat is computed from P_CRC_INIT, not from the stale register.
  - in_frame is set on a start beat with rlast=0.
  - in_frame is cleared on any valid beat with rlast=1.
  - A single-beat frame (start beat with rlast=1) is legal.
- Gaps: rvalid may drop mid-frame. The CRC register and byte counter hold. No timeout.
- CRC datapath:
  - Reflected IEEE 802.3 polynomial 0x04C11DB7 (LSB-first, 0xEDB88320 form).
  - Bytes processed in order byte0..byte7. Only bytes with keep=1 update the CRC.
  - Implemented as combinational per-byte-count folds (keep popcount 1..8), selected by keep, then registered. One beat is absorbed per clock, full throughput.
- Keep rules:
  - On non-last beats, keep must be 8'hFF.
  - On the last beat, keep must be one of 8'h01, 8'h03, ..., 8'hFF.
  - Any other keep value on a valid beat sets a sticky bad_keep flag for the current frame; bad_keep forces crc_error=1.
  - keep=8'h00 on a valid beat counts as bad_keep.
- Verdict timing:
  - o_crc_valid pulses for exactly 1 cycle, 2 clocks after the s_axis_rlast beat, i.e. 1 clock after m_axis_rlast.
  - o_crc_error = (final CRC register != P_RESIDUE) | bad_keep | runt (runt only with RUNT_CHECK_EN).
  - o_crc_error is 0 whenever o_crc_valid is 0.
- Back-to-back frames: a new start beat in the cycle immediately after rlast is handled; the verdict pipeline is independent of the new frame's CRC register.
- Byte counter: 16-bit, saturates at 16'hFFFF, cleared at frame start.
- Reset mid-frame: the partial frame is discarded with no verdict pulse. The next valid beat after release is a start beat.

Optional Feature:
RUNT_CHECK_EN
- Defined: a frame whose total valid byte count is below P_MIN_BYTES gets o_crc_error=1, even if the CRC is correct.
- Not defined: the byte counter and runt logic are removed; the verdict is CRC plus keep only.

Test Plan:
All scenarios run with RUNT_CHECK_EN undefined unless noted. FCS-valid test frame used below: beat0 data=64'h3837363534333231, keep=FF; beat1 data=64'h000000CBF4392639, keep=1F, last. This is "123456789" plus FCS CBF43926.
1. Good frame: send the test frame -> m_axis echoes both beats 1 cycle later; o_crc_valid=1, o_crc_error=0 exactly 2 cycles after the beat1 input.
2. Corrupt frame: same frame with beat0 byte2 changed to 0x34 -> o_crc_valid=1, o_crc_error=1.
3. Gap plus back-to-back: frame from scenario 1 with 3 idle cycles between beats, immediately followed by the scenario-2 frame -> two verdict pulses, errors 0 then 1, no lost beats.
4. Bad keep: good frame but beat1 keep=8'h15 -> o_crc_error=1. Non-last beat keep=8'h7F -> o_crc_error=1.
5. Reset mid-frame: assert i_rst_n=0 after beat0, release, then send the good frame -> outputs 0 during reset, exactly one pulse, error=0.
6. RUNT_CHECK_EN defined: the 13-byte good frame -> o_crc_error=1. A 64-byte frame with correct FCS -> o_crc_error=0.
